// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern generator.
// A single registered output stage keeps position, syncs, de and RGB aligned.
module vga_pattern_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int COLOR_W   = 4,
    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
    localparam int HC_W     = $clog2(H_TOTAL),
    localparam int VC_W     = $clog2(V_TOTAL)
) (
    input  logic                 vgaclk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] fg_rgb,
    output logic [HC_W-1:0]      hc_out,
    output logic [VC_W-1:0]      vc_out,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 frame_start,
    output logic [7:0]           frame_cnt
);
    localparam int BAR_W = H_VISIBLE / 8;
    localparam int BP_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int HS_LO = H_VISIBLE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC - 1;
    localparam int VS_LO = V_VISIBLE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC - 1;
    localparam logic HS_ON = 1'(HSYNC_POL);
    localparam logic VS_ON = 1'(VSYNC_POL);

    logic [HC_W-1:0]      hc_q, hc_d;
    logic [VC_W-1:0]      vc_q, vc_d;
    logic [BP_W-1:0]      bpx_q, bpx_d;
    logic [2:0]           bar_q, bar_d;
    logic [1:0]           pat_q, pat_d;
    logic                 line_end, frame_end, origin;
    logic                 de_d, hs_d, vs_d;
    logic                 hb5, vb5;
    logic [COLOR_W-1:0]   grey_d;
    logic [3*COLOR_W-1:0] rgb_d;

    // Next raster position, bar tracking and frame-synchronised pattern
    always_comb begin
        line_end  = (hc_q == HC_W'(H_TOTAL - 1));
        frame_end = line_end && (vc_q == VC_W'(V_TOTAL - 1));
        origin    = (hc_q == '0) && (vc_q == '0);
        hc_d      = line_end ? '0 : hc_q + HC_W'(1);
        vc_d      = vc_q;
        if (line_end) begin
            vc_d = frame_end ? '0 : vc_q + VC_W'(1);
        end
        bpx_d = bpx_q + BP_W'(1);
        bar_d = bar_q;
        if (line_end) begin
            bpx_d = '0;
            bar_d = '0;
        end else if (bpx_q == BP_W'(BAR_W - 1)) begin
            bpx_d = '0;
            bar_d = bar_q + 3'd1;
        end
        pat_d = origin ? mode : pat_q;
    end

    // Pixel attributes of the current raster position
    always_comb begin
        de_d = (hc_q < HC_W'(H_VISIBLE)) && (vc_q < VC_W'(V_VISIBLE));
        hs_d = (hc_q >= HC_W'(HS_LO) && hc_q <= HC_W'(HS_HI)) ? HS_ON : ~HS_ON;
        vs_d = (vc_q >= VC_W'(VS_LO) && vc_q <= VC_W'(VS_HI)) ? VS_ON : ~VS_ON;
        hb5    = |(hc_q & HC_W'(32));
        vb5    = |(vc_q & VC_W'(32));
        grey_d = COLOR_W'(hc_q >> 6);
        rgb_d  = '0;
        unique case (pat_d)
            2'd0: rgb_d = fg_rgb;
            2'd1: rgb_d = {{COLOR_W{bar_q[0]}},
                           {COLOR_W{bar_q[1]}},
                           {COLOR_W{bar_q[2]}}};
            2'd2: rgb_d = (hb5 ^ vb5) ? '0 : fg_rgb;
            2'd3: rgb_d = {grey_d, grey_d, grey_d};
            default: rgb_d = '0;
        endcase
        if (!de_d) begin
            rgb_d = '0;
        end
    end

    // Raster counters and latched pattern advance only on enabled cycles
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            hc_q  <= '0;
            vc_q  <= '0;
            bpx_q <= '0;
            bar_q <= '0;
            pat_q <= '0;
        end else if (pix_en) begin
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            bpx_q <= bpx_d;
            bar_q <= bar_d;
            pat_q <= pat_d;
        end
    end

    // Output register; frame_start drops on every edge that is not enabled
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            hc_out      <= '0;
            vc_out      <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_start <= pix_en && origin;
            if (pix_en) begin
                hc_out               <= hc_q;
                vc_out               <= vc_q;
                hsync                <= hs_d;
                vsync                <= vs_d;
                de                   <= de_d;
                {red, green, blue}   <= rgb_d;
                if (frame_end) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized bench against a linear-pixel-index model.
// A second, tiny-mode instance covers polarity and the frame counter wrap.
module tb_vga_pattern_gen;
    localparam int HV  = 640;
    localparam int HFP = 16;
    localparam int HS  = 96;
    localparam int HBP = 48;
    localparam int VV  = 12;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FR  = HT * VT;
    localparam int S_FR = 12 * 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] fg = 12'h000;
    logic [9:0]  hc_out;
    logic [3:0]  vc_out;
    logic        hsync, vsync, de;
    logic [3:0]  red, green, blue;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    logic        rst2 = 1'b0;
    logic        s_en = 1'b1;
    logic [1:0]  s_mode = 2'd1;
    logic [11:0] s_fg = 12'hABC;
    logic [3:0]  s_hc;
    logic [2:0]  s_vc;
    logic        s_hs, s_vs, s_de;
    logic [3:0]  s_r, s_g, s_b;
    logic        s_fs;
    logic [7:0]  s_fc;

    int checks = 0;
    int errors = 0;

    int          m_p, m_pat, m_fcnt;
    int          e_hc, e_vc;
    logic        e_hs, e_vs, e_de, e_fs;
    logic [11:0] e_rgb;

    vga_pattern_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_W(4)
    ) dut (
        .vgaclk(clk), .rst(rst), .pix_en(pix_en), .mode(mode),
        .fg_rgb(fg), .hc_out(hc_out), .vc_out(vc_out),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    vga_pattern_gen #(
        .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .COLOR_W(4)
    ) dut_s (
        .vgaclk(clk), .rst(rst2), .pix_en(s_en), .mode(s_mode),
        .fg_rgb(s_fg), .hc_out(s_hc), .vc_out(s_vc),
        .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .red(s_r), .green(s_g), .blue(s_b),
        .frame_start(s_fs), .frame_cnt(s_fc)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] dut_vec();
        return {hc_out, vc_out, hsync, vsync, de,
                red, green, blue, frame_start, frame_cnt};
    endfunction

    function automatic logic [37:0] exp_vec();
        return {10'(e_hc), 4'(e_vc), e_hs, e_vs, e_de,
                e_rgb, e_fs, 8'(m_fcnt)};
    endfunction

    task automatic model_reset();
        m_p = 0; m_pat = 0; m_fcnt = 0;
        e_hc = 0; e_vc = 0; e_hs = 1'b1; e_vs = 1'b1;
        e_de = 1'b0; e_rgb = 12'h000; e_fs = 1'b0;
    endtask

    // Pixel index p walks 0..FR-1; (h, v) are derived from it.
    task automatic model_edge();
        int h, v, k;
        logic [3:0] g;
        e_fs = 1'b0;
        if (pix_en) begin
            h = m_p % HT;
            v = m_p / HT;
            if (m_p == 0) begin
                m_pat = int'(mode);
                e_fs = 1'b1;
            end
            e_hc = h;
            e_vc = v;
            e_hs = (h >= HV + HFP && h < HV + HFP + HS) ? 1'b0 : 1'b1;
            e_vs = (v >= VV + VFP && v < VV + VFP + VS) ? 1'b0 : 1'b1;
            e_de = (h < HV) && (v < VV);
            case (m_pat)
                0: e_rgb = fg;
                1: begin
                    k = h / (HV / 8);
                    e_rgb = {(k % 2 == 1) ? 4'hF : 4'h0,
                             ((k / 2) % 2 == 1) ? 4'hF : 4'h0,
                             ((k / 4) % 2 == 1) ? 4'hF : 4'h0};
                end
                2: e_rgb = ((h / 32 + v / 32) % 2 == 0) ? fg : 12'h000;
                default: begin
                    g = 4'((h / 64) % 16);
                    e_rgb = {g, g, g};
                end
            endcase
            if (!e_de) e_rgb = 12'h000;
            if (m_p == FR - 1) m_fcnt = (m_fcnt + 1) % 256;
            m_p = (m_p + 1) % FR;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b1;
        rst2 = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({hsync, vsync, de} !== 3'b110) begin
            errors++;
            $display("FAIL reset_sync: got %b want 110", {hsync, vsync, de});
        end
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb: got %h want 000", {red, green, blue});
        end
        checks++;
        if (frame_cnt !== 8'd0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame: got cnt %0d fs %b want 0 0",
                     frame_cnt, frame_start);
        end
        checks++;
        if ({hc_out, vc_out} !== 14'd0) begin
            errors++;
            $display("FAIL reset_pos: got %0d,%0d want 0,0", hc_out, vc_out);
        end
        checks++;
        if ({s_hs, s_vs, s_de} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pol: got %b want 000", {s_hs, s_vs, s_de});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({hc_out, vc_out, de, frame_start} !== {14'd0, 2'b11}) begin
            errors++;
            $display("FAIL first_edge: got %0d,%0d de %b fs %b want 0,0 1 1",
                     hc_out, vc_out, de, frame_start);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL first_vec: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_line_frame();
        int fs1 = -1, fs2 = -1, hs_n = 0, hs_first = -1, de_n = 0;
        int vmin = 99, vmax = -1, prev_hc = -1, prev_vc = -1;
        do_reset();
        for (int i = 0; i < FR + 2; i++) begin
            if (i % 97 == 50) begin
                mode = 2'($urandom);
                fg = 12'($urandom);
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL line_frame: got %h want %h at i=%0d",
                         dut_vec(), exp_vec(), i);
            end
            if (frame_start) begin
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
            if (i < HT) begin
                if (!hsync) begin
                    hs_n++;
                    if (hs_first < 0) hs_first = int'(hc_out);
                end
                if (de) de_n++;
            end
            if (i < FR && !vsync) begin
                if (int'(vc_out) < vmin) vmin = int'(vc_out);
                if (int'(vc_out) > vmax) vmax = int'(vc_out);
            end
            if (prev_hc == HT - 1) begin
                checks++;
                if (hc_out !== 10'd0 || vc_out !== 4'((prev_vc + 1) % VT)) begin
                    errors++;
                    $display("FAIL hc_wrap: got %0d,%0d after %0d,%0d",
                             hc_out, vc_out, prev_hc, prev_vc);
                end
            end
            prev_hc = int'(hc_out);
            prev_vc = int'(vc_out);
        end
        checks++;
        if (hs_n != HS || hs_first != HV + HFP) begin
            errors++;
            $display("FAIL hsync_width: got %0d from %0d want %0d from %0d",
                     hs_n, hs_first, HS, HV + HFP);
        end
        checks++;
        if (de_n != HV) begin
            errors++;
            $display("FAIL de_width: got %0d want %0d", de_n, HV);
        end
        checks++;
        if (vmin != VV + VFP || vmax != VV + VFP + VS - 1) begin
            errors++;
            $display("FAIL vsync_lines: got %0d..%0d want %0d..%0d",
                     vmin, vmax, VV + VFP, VV + VFP + VS - 1);
        end
        checks++;
        if (fs2 - fs1 != FR) begin
            errors++;
            $display("FAIL frame_period: got %0d want %0d", fs2 - fs1, FR);
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        for (int i = 0; i < FR && !found; i++) begin
            if (i % 211 == 0) begin
                mode = 2'($urandom);
                fg = 12'($urandom);
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pre_reset: got %h want %h", dut_vec(), exp_vec());
            end
            if (hc_out == 10'd300 && vc_out == 4'd10) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_300_10: got no hit want hit");
        end
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset_cnt: got %0d want 1", frame_cnt);
        end
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (dut_vec() !== {14'd0, 3'b110, 12'h000, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset: got %h want reset state", dut_vec());
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({hc_out, vc_out, de, frame_start, frame_cnt} !==
            {14'd0, 2'b11, 8'd0}) begin
            errors++;
            $display("FAIL restart: got %0d,%0d de %b fs %b cnt %0d",
                     hc_out, vc_out, de, frame_start, frame_cnt);
        end
        for (int i = 0; i < 900; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset: got %h want %h",
                         dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_mode_latch();
        bit hit = 0;
        mode = 2'd0;
        fg = 12'h0F0;
        do_reset();
        for (int i = 0; i < FR && !hit; i++) begin
            tick();
            if (vc_out == 4'd6) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_line6: got no hit want hit");
        end
        mode = 2'd1;
        hit = 0;
        for (int i = 0; i < FR + 10 && !hit; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL latch_vec: got %h want %h", dut_vec(), exp_vec());
            end
            if (frame_start) begin
                hit = 1;
            end else begin
                checks++;
                if ({red, green, blue} !== (de ? 12'h0F0 : 12'h000)) begin
                    errors++;
                    $display("FAIL latch_hold: got %h at %0d,%0d",
                             {red, green, blue}, hc_out, vc_out);
                end
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL next_frame: got no frame_start want one");
        end
        for (int i = 0; i < HT; i++) begin
            tick();
            if (hc_out >= 10'd80 && hc_out <= 10'd159) begin
                checks++;
                if ({red, green, blue} !== 12'hF00) begin
                    errors++;
                    $display("FAIL bar1: got %h want F00 at %0d",
                             {red, green, blue}, hc_out);
                end
            end
            if (hc_out >= 10'd560 && hc_out <= 10'd639) begin
                checks++;
                if ({red, green, blue} !== 12'hFFF) begin
                    errors++;
                    $display("FAIL bar7: got %h want FFF at %0d",
                             {red, green, blue}, hc_out);
                end
            end
        end
    endtask

    task automatic test_enable_gating();
        int fs_n = 0, hs_n = 0;
        do_reset();
        for (int i = 0; i < 2 * HT + 10; i++) begin
            pix_en = (i % 2 == 0);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL gate_vec: got %h want %h", dut_vec(), exp_vec());
            end
            if (frame_start) fs_n++;
            if (!hsync && vc_out == 4'd0) hs_n++;
        end
        checks++;
        if (fs_n != 1) begin
            errors++;
            $display("FAIL fs_width: got %0d want 1", fs_n);
        end
        checks++;
        if (hs_n != 2 * HS) begin
            errors++;
            $display("FAIL gate_hsync: got %0d want %0d", hs_n, 2 * HS);
        end
        for (int i = 0; i < 1500; i++) begin
            pix_en = 1'($urandom);
            if (i % 101 == 0) begin
                mode = 2'($urandom);
                fg = 12'($urandom);
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_gate: got %h want %h", dut_vec(), exp_vec());
            end
        end
        pix_en = 1'b1;
    endtask

    task automatic test_frame_wrap();
        int f = 0, last = -1, hs_n = 0, vs_n = 0, de_n = 0;
        rst2 = 1'b0;
        for (int i = 0; i < 257 * S_FR + 20; i++) begin
            tick();
            if (s_fs) begin
                checks++;
                if (s_fc !== 8'(f) || s_hc !== 4'd0 || s_vc !== 3'd0) begin
                    errors++;
                    $display("FAIL wrap_cnt: got %0d at %0d,%0d want %0d",
                             s_fc, s_hc, s_vc, f % 256);
                end
                if (last >= 0) begin
                    checks++;
                    if (i - last != S_FR) begin
                        errors++;
                        $display("FAIL s_period: got %0d want %0d",
                                 i - last, S_FR);
                    end
                end
                last = i;
                f++;
                if (f == 257) break;
            end
            if (f == 1) begin
                if (s_hs) hs_n++;
                if (s_vs) vs_n++;
                if (s_de) de_n++;
            end
            if (!s_de) begin
                checks++;
                if ({s_r, s_g, s_b} !== 12'h000) begin
                    errors++;
                    $display("FAIL s_blank: got %h want 000", {s_r, s_g, s_b});
                end
            end
        end
        checks++;
        if (f != 257) begin
            errors++;
            $display("FAIL s_frames: got %0d want 257", f);
        end
        checks++;
        if (hs_n != 14 || vs_n != 12 || de_n != 32) begin
            errors++;
            $display("FAIL s_counts: got hs %0d vs %0d de %0d want 14 12 32",
                     hs_n, vs_n, de_n);
        end
    endtask

    initial begin
        test_reset();
        test_line_frame();
        test_async_reset();
        test_mode_latch();
        test_enable_gating();
        test_frame_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
